// File: rtl/sram_dp.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp
//  Description : Simple dual-port synchronous RAM (one write port, one read
//                port, single clock) with registered read data, read-valid
//                strobe, selectable read-during-write behaviour and a
//                post-reset clear sweep that zeroes every word.
//                Optional even-parity protection is compiled in when the
//                macro SRAM_DP_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_dp #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inject_err,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              parity_err
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef SRAM_DP_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // Terminal count of the sweep; the counter carries one spare bit so the
  // last address is recognised without relying on wrap-around.
  localparam logic [ADDR_W:0] c_last = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam state_t c_rst_state = (CLEAR_ON_RST != 0) ? CLEAR : IDLE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [MEM_W-1:0]  w_wword;
  logic              w_wen;
  logic [ADDR_W-1:0] w_wa;
  logic [MEM_W-1:0]  w_wd;
  logic [MEM_W-1:0]  w_rword;
  logic              w_perr;

  assign busy = (r_state == CLEAR);

  // State and sweep-counter register; reset restarts the sweep at address 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_rst_state;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: the sweep advances one word per cycle until the last one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE:    w_state_nxt = IDLE;
      default: w_state_nxt = c_rst_state;
    endcase
  end

  // Stored write word: data plus even parity (optionally inverted) when enabled.
`ifdef SRAM_DP_PARITY_EN
  assign w_wword = {(^wdata) ^ inject_err, wdata};
`else
  logic w_unused;
  assign w_unused = inject_err;
  assign w_wword  = wdata;
`endif

  // Write-port mux: the sweep owns the array while busy; an all-zero word
  // already carries correct even parity.
  always_comb begin
    w_wen = we;
    w_wa  = waddr;
    w_wd  = w_wword;
    if (busy) begin
      w_wen = 1'b1;
      w_wa  = r_cnt[ADDR_W-1:0];
      w_wd  = '0;
    end
  end

  // Storage array; no writes are accepted while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && w_wen) begin
      mem[w_wa] <= w_wd;
    end
  end

  // Read-during-write selection for a same-address collision.
  generate
    if (RDW_MODE == 1) begin : g_rdw_new
      assign w_rword = (we && (waddr == raddr)) ? w_wword : mem[raddr];
    end else begin : g_rdw_old
      assign w_rword = mem[raddr];
    end
  endgenerate

`ifdef SRAM_DP_PARITY_EN
  assign w_perr = (^w_rword[DATA_W-1:0]) != w_rword[DATA_W];
`else
  assign w_perr = 1'b0;
`endif

  // Registered read port: one-cycle latency, rdata holds between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      parity_err <= 1'b0;
    end else if ((r_state == IDLE) && re) begin
      rdata      <= w_rword[DATA_W-1:0];
      rvalid     <= 1'b1;
      parity_err <= w_perr;
    end else begin
      rvalid     <= 1'b0;
      parity_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire
